// File: rtl/chunk_pingpong_ctrl_pkg.sv
// Shared configuration for the ping-pong chunk sequencer: sizes, state
// encoding and bank index type.
package chunk_pingpong_ctrl_pkg;

  localparam int CFG_NUM_CHUNKS = 64;
  localparam int CFG_IDX_W      = 7;
  localparam int CFG_ADDR_W     = 12;

  typedef logic bank_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_STEP,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/chunk_pingpong_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the DDR mover / LBM
// core side (slave).
interface chunk_pingpong_ctrl_if
  import chunk_pingpong_ctrl_pkg::*;
#(
  parameter int IDX_W = CFG_IDX_W
);
  logic             start;
  logic             busy;
  logic             frame_done;
  logic             xfer_req;
  bank_t            xfer_bank;
  logic             xfer_wb_valid;
  logic [IDX_W-1:0] xfer_wb_idx;
  logic             xfer_ld_valid;
  logic [IDX_W-1:0] xfer_ld_idx;
  logic             xfer_done;
  logic             comp_req;
  bank_t            comp_bank;
  logic [IDX_W-1:0] comp_idx;
  logic             comp_done;
  logic [1:0]       bank_xfer_sel;
  logic [1:0]       bank_comp_sel;

  modport master (
    input  start, xfer_done, comp_done,
    output busy, frame_done,
    output xfer_req, xfer_bank, xfer_wb_valid, xfer_wb_idx, xfer_ld_valid, xfer_ld_idx,
    output comp_req, comp_bank, comp_idx,
    output bank_xfer_sel, bank_comp_sel
  );

  modport slave (
    output start, xfer_done, comp_done,
    input  busy, frame_done,
    input  xfer_req, xfer_bank, xfer_wb_valid, xfer_wb_idx, xfer_ld_valid, xfer_ld_idx,
    input  comp_req, comp_bank, comp_idx,
    input  bank_xfer_sel, bank_comp_sel
  );
endinterface

// File: rtl/chunk_pingpong_ctrl_hs.sv
// One request/done side: holds the req level, its bank select and the done
// flag; a side launched with issue=0 is marked complete immediately.
module chunk_hs_tracker
  import chunk_pingpong_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       launch,
  input  logic       issue,
  input  bank_t      bank_in,
  input  logic       clear,
  input  logic       done,
  output logic       req,
  output logic       flag,
  output bank_t      bank,
  output logic [1:0] sel
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req  <= 1'b0;
      flag <= 1'b0;
      bank <= 1'b0;
      sel  <= 2'b00;
    end else if (clear) begin
      req  <= 1'b0;
      flag <= 1'b0;
      bank <= 1'b0;
      sel  <= 2'b00;
    end else if (launch) begin
      req  <= issue;
      flag <= ~issue;
      bank <= issue ? bank_in : 1'b0;
      sel  <= issue ? (bank_in ? 2'b10 : 2'b01) : 2'b00;
    end else if (req && done) begin
      // bank is kept so the muxes see a stable index until the step closes
      req  <= 1'b0;
      flag <= 1'b1;
      sel  <= 2'b00;
    end
  end

endmodule

// File: rtl/chunk_pingpong_ctrl.sv
// Ping-pong bank sequencer: preload chunk 0, then overlap compute of chunk k
// with writeback of k-1 / load of k+1 in the opposite bank, one GAP per swap.
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// PRELOAD | mover loads chunk 0 into bank 0
// STEP    | compute k on bank k[0], transfer on bank ~k[0]
// GAP     | one cycle with both reqs low before the next STEP
// DONE    | frame_done pulse, then back to IDLE
module chunk_pingpong_ctrl
  import chunk_pingpong_ctrl_pkg::*;
#(
  parameter int NUM_CHUNKS = CFG_NUM_CHUNKS,
  parameter int IDX_W      = CFG_IDX_W
)(
  input  logic                  clk,
  input  logic                  rst_n,
  chunk_pingpong_ctrl_if.master bus
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_CHUNKS);

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [IDX_W:0]   k_ext;
  logic             comp_en, wb_en, ld_en, last_step;
  logic             x_flag, c_flag, x_fin, c_fin;
  logic             x_launch, x_issue, c_launch, trk_clear;
  bank_t            x_bank_in;

  always_comb begin
    k_ext     = {1'b0, k};
    comp_en   = k_ext < N_EXT;
    wb_en     = k != '0;
    ld_en     = (k_ext + 1'b1) < N_EXT;
    last_step = k_ext == N_EXT;
    x_fin     = x_flag | (bus.xfer_req & bus.xfer_done);
    c_fin     = c_flag | (bus.comp_req & bus.comp_done);

    x_launch  = 1'b0;
    x_issue   = 1'b0;
    x_bank_in = 1'b0;
    c_launch  = 1'b0;
    trk_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        x_launch = bus.start;
        x_issue  = 1'b1;
      end
      ST_PRELOAD: trk_clear = x_fin;
      ST_GAP: begin
        x_launch  = 1'b1;
        x_issue   = wb_en | ld_en;
        x_bank_in = ~k[0];
        c_launch  = 1'b1;
      end
      ST_STEP: trk_clear = x_fin & c_fin;
      default: ;
    endcase
  end

  chunk_hs_tracker u_xfer (
    .clk     (clk),
    .rst_n   (rst_n),
    .launch  (x_launch),
    .issue   (x_issue),
    .bank_in (x_bank_in),
    .clear   (trk_clear),
    .done    (bus.xfer_done),
    .req     (bus.xfer_req),
    .flag    (x_flag),
    .bank    (bus.xfer_bank),
    .sel     (bus.bank_xfer_sel)
  );

  chunk_hs_tracker u_comp (
    .clk     (clk),
    .rst_n   (rst_n),
    .launch  (c_launch),
    .issue   (comp_en),
    .bank_in (k[0]),
    .clear   (trk_clear),
    .done    (bus.comp_done),
    .req     (bus.comp_req),
    .flag    (c_flag),
    .bank    (bus.comp_bank),
    .sel     (bus.bank_comp_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      k                 <= '0;
      bus.busy          <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.xfer_wb_valid <= 1'b0;
      bus.xfer_wb_idx   <= '0;
      bus.xfer_ld_valid <= 1'b0;
      bus.xfer_ld_idx   <= '0;
      bus.comp_idx      <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start) begin
          state             <= ST_PRELOAD;
          k                 <= '0;
          bus.busy          <= 1'b1;
          bus.xfer_wb_valid <= 1'b0;
          bus.xfer_wb_idx   <= '0;
          bus.xfer_ld_valid <= 1'b1;
          bus.xfer_ld_idx   <= '0;
        end
        ST_PRELOAD: if (x_fin) begin
          state             <= ST_GAP;
          bus.xfer_ld_valid <= 1'b0;
        end
        ST_GAP: begin
          state             <= ST_STEP;
          bus.comp_idx      <= comp_en ? k : '0;
          bus.xfer_wb_valid <= wb_en;
          bus.xfer_wb_idx   <= wb_en ? k - 1'b1 : '0;
          bus.xfer_ld_valid <= ld_en;
          bus.xfer_ld_idx   <= ld_en ? k + 1'b1 : '0;
        end
        ST_STEP: if (x_fin && c_fin) begin
          bus.comp_idx      <= '0;
          bus.xfer_wb_valid <= 1'b0;
          bus.xfer_wb_idx   <= '0;
          bus.xfer_ld_valid <= 1'b0;
          bus.xfer_ld_idx   <= '0;
          if (last_step) begin
            state          <= ST_DONE;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b1;
          end else begin
            state <= ST_GAP;
            k     <= k + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_pingpong_ctrl.sv
// Directed bench: an N=4 and an N=1 sequencer driven through preload, steps,
// simultaneous/spurious dones, mid-frame reset and ignored restarts.
module tb_chunk_pingpong_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic use1 = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  chunk_pingpong_ctrl_if #(.IDX_W(7)) if4 ();
  chunk_pingpong_ctrl_if #(.IDX_W(7)) if1 ();

  chunk_pingpong_ctrl #(.NUM_CHUNKS(4), .IDX_W(7)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  chunk_pingpong_ctrl #(.NUM_CHUNKS(1), .IDX_W(7)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic       x_req, c_req, x_bank, c_bank, wbv, ldv, busy, fdone;
  logic [6:0] wbi, ldi, cidx;
  logic [1:0] xsel, csel;
  assign x_req  = use1 ? if1.xfer_req      : if4.xfer_req;
  assign c_req  = use1 ? if1.comp_req      : if4.comp_req;
  assign x_bank = use1 ? if1.xfer_bank     : if4.xfer_bank;
  assign c_bank = use1 ? if1.comp_bank     : if4.comp_bank;
  assign wbv    = use1 ? if1.xfer_wb_valid : if4.xfer_wb_valid;
  assign ldv    = use1 ? if1.xfer_ld_valid : if4.xfer_ld_valid;
  assign wbi    = use1 ? if1.xfer_wb_idx   : if4.xfer_wb_idx;
  assign ldi    = use1 ? if1.xfer_ld_idx   : if4.xfer_ld_idx;
  assign cidx   = use1 ? if1.comp_idx      : if4.comp_idx;
  assign xsel   = use1 ? if1.bank_xfer_sel : if4.bank_xfer_sel;
  assign csel   = use1 ? if1.bank_comp_sel : if4.bank_comp_sel;
  assign busy   = use1 ? if1.busy          : if4.busy;
  assign fdone  = use1 ? if1.frame_done    : if4.frame_done;

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      assert (((if4.bank_xfer_sel & if4.bank_comp_sel) | (if1.bank_xfer_sel & if1.bank_comp_sel)) === 2'b00)
        else begin
          miscompares++;
          $error("FAIL sel_overlap: observed %b/%b expected no common bank", if4.bank_xfer_sel, if4.bank_comp_sel);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic set_done(input logic xd, input logic cd);
    if4.xfer_done = xd;
    if1.xfer_done = xd;
    if4.comp_done = cd;
    if1.comp_done = cd;
  endtask

  task automatic pulse_start();
    if (use1) if1.start = 1'b1; else if4.start = 1'b1;
    tick();
    if1.start = 1'b0;
    if4.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " fdone"}, fdone, 0);
    chk({tag, " xreq"}, x_req, 0);
    chk({tag, " creq"}, c_req, 0);
    chk({tag, " xsel"}, xsel, 0);
    chk({tag, " csel"}, csel, 0);
    chk({tag, " xbank"}, x_bank, 0);
    chk({tag, " cbank"}, c_bank, 0);
    chk({tag, " fields"}, {wbv, ldv, wbi, ldi, cidx}, 0);
  endtask

  // Called on the first cycle of a request phase; ends on the first cycle of
  // the next phase (after the GAP) or in IDLE after frame_done.
  task automatic step(input string tag, input bit cr, input bit cb, input int ci,
                      input bit xr, input bit xb, input bit wv, input int wi,
                      input bit lv, input int li, input int lx, input int lc,
                      input int spur_c, input bit last);
    int m;
    chk({tag, " creq"}, c_req, cr);
    chk({tag, " xreq"}, x_req, xr);
    chk({tag, " csel"}, csel, cr ? (cb ? 2 : 1) : 0);
    chk({tag, " xsel"}, xsel, xr ? (xb ? 2 : 1) : 0);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " wbv"}, wbv, wv);
    chk({tag, " ldv"}, ldv, lv);
    if (cr) begin
      chk({tag, " cbank"}, c_bank, cb);
      chk({tag, " cidx"}, cidx, ci);
    end
    if (xr) chk({tag, " xbank"}, x_bank, xb);
    if (wv) chk({tag, " wbi"}, wbi, wi);
    if (lv) chk({tag, " ldi"}, ldi, li);
    m = -1;
    if (xr && lx > m) m = lx;
    if (cr && lc > m) m = lc;
    for (int c = 0; c <= m; c++) begin
      set_done(xr && c == lx, (cr && c == lc) || c == spur_c);
      tick();
      set_done(1'b0, 1'b0);
      if (xr && c == lx) chk({tag, " xdrop"}, x_req, 0);
      if (cr && c == lc) chk({tag, " cdrop"}, c_req, 0);
      if (xr && c < lx) chk({tag, " xhold"}, x_req, 1);
    end
    if (!last) begin
      chk({tag, " gap reqs"}, {x_req, c_req, xsel, csel}, 0);
      chk({tag, " gap busy"}, busy, 1);
      tick();
    end else begin
      chk({tag, " fdone"}, fdone, 1);
      chk({tag, " done busy"}, busy, 0);
      chk({tag, " done reqs"}, {x_req, c_req}, 0);
      tick();
      chk_all_zero({tag, " idle"});
    end
  endtask

  initial begin
    if4.start = 1'b0;
    if1.start = 1'b0;
    set_done(1'b0, 1'b0);
    tick();
    tick();
    chk_all_zero("reset4");
    rst_n = 1'b1;
    tick();

    // spurious dones while idle
    set_done(1'b1, 1'b1);
    tick();
    set_done(1'b0, 1'b0);
    chk_all_zero("idle_spur");

    // N=4, 10-cycle mover and LBM
    pulse_start();
    step("A pre", 0, 0, 0, 1, 0, 0, 0, 1, 0, 9, 9, -1, 0);
    step("A k0",  1, 0, 0, 1, 1, 0, 0, 1, 1, 9, 9, -1, 0);
    step("A k1",  1, 1, 1, 1, 0, 1, 0, 1, 2, 9, 9, -1, 0);
    step("A k2",  1, 0, 2, 1, 1, 1, 1, 1, 3, 9, 9, -1, 0);
    step("A k3",  1, 1, 3, 1, 0, 1, 2, 0, 0, 9, 9, -1, 0);
    step("A k4",  0, 0, 0, 1, 1, 1, 3, 0, 0, 9, 9, -1, 1);
    chk("A fdone once", fdone, 0);

    // simultaneous dones on the first high cycle of every phase
    pulse_start();
    step("B pre", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, -1, 0);
    step("B k0",  1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, -1, 0);
    step("B k1",  1, 1, 1, 1, 0, 1, 0, 1, 2, 0, 0, -1, 0);
    step("B k2",  1, 0, 2, 1, 1, 1, 1, 1, 3, 0, 0, -1, 0);
    step("B k3",  1, 1, 3, 1, 0, 1, 2, 0, 0, 0, 0, -1, 0);
    step("B k4",  0, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0, -1, 1);

    // spurious comp_done while comp_req low, then reset in STEP 2
    pulse_start();
    step("D pre", 0, 0, 0, 1, 0, 0, 0, 1, 0, 5, 0, 2, 0);
    step("D k0",  1, 0, 0, 1, 1, 0, 0, 1, 1, 6, 1, 3, 0);
    step("D k1",  1, 1, 1, 1, 0, 1, 0, 1, 2, 1, 2, -1, 0);
    chk("D k2 reqs", {x_req, c_req}, 2'b11);
    chk("D k2 cidx", cidx, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all_zero("D rst");
    tick();
    chk_all_zero("D rst idle");

    // fresh frame replays from preload; start during STEP is ignored
    pulse_start();
    step("E pre", 0, 0, 0, 1, 0, 0, 0, 1, 0, 3, 0, -1, 0);
    pulse_start();
    chk("E ign reqs", {x_req, c_req}, 2'b11);
    chk("E ign cidx", cidx, 0);
    chk("E ign ldi", ldi, 1);
    set_done(1'b1, 1'b1);
    tick();
    set_done(1'b0, 1'b0);
    chk("E k0 gap", {x_req, c_req, xsel, csel}, 0);
    tick();
    step("E k1",  1, 1, 1, 1, 0, 1, 0, 1, 2, 2, 2, -1, 0);
    step("E k2",  1, 0, 2, 1, 1, 1, 1, 1, 3, 2, 2, -1, 0);
    step("E k3",  1, 1, 3, 1, 0, 1, 2, 0, 0, 2, 2, -1, 0);
    step("E k4",  0, 0, 0, 1, 1, 1, 3, 0, 0, 2, 2, -1, 1);

    // N=1 instance
    use1 = 1'b1;
    chk_all_zero("N1 idle");
    pulse_start();
    step("N1 pre", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4, 0, -1, 0);
    step("N1 k0",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, -1, 0);
    step("N1 k1",  0, 0, 0, 1, 0, 1, 0, 0, 0, 4, 0, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
